// File: rtl/int_to_fp8_encoder.sv
// int_to_fp8_encoder: signed IN_W-bit integer -> fp8 {sign, expo[3:0], mant[2:0]}, one normalising shift per cycle.
// Latency: accept edge to out_valid is (leading-zero shift count + 2) cycles; one conversion in flight at a time.
// Backpressure: in_ready only in IDLE; out_data held with out_valid until out_ready. Build option INT_TO_FP8_ROUND_EN selects round-to-nearest-even.
module int_to_fp8_encoder #(
  parameter int IN_W = 8,
  parameter int BIAS = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_data,
  output logic            busy
);

  localparam int CNT_W = $clog2(IN_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    PACK = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              sign_q, sign_d;
  logic [IN_W-1:0]   mag_q, mag_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  logic [IN_W-1:0]   abs_in;
  logic [2:0]        mant_t;
  logic [2:0]        mant_r;
  logic [5:0]        expo_t;
  logic [5:0]        expo_r;
  logic [7:0]        packed_res;

`ifdef INT_TO_FP8_ROUND_EN
  // Bits below the guard bit; empty when IN_W is 5.
  localparam logic [IN_W-1:0] STICKY_MASK = {IN_W{1'b1}} >> 5;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic [3:0]        mant_sum;
`endif

  // Magnitude of the incoming integer; the most negative value maps to 2^(IN_W-1).
  always_comb begin
    abs_in = in_data;
    if (in_data[IN_W-1]) begin
      abs_in = ~in_data + IN_W'(1);
    end
  end

  // Pack the normalised magnitude into the fp8 fields, with optional rounding and saturation.
  always_comb begin
    mant_t = mag_q[IN_W-2 -: 3];
    expo_t = 6'(BIAS + IN_W - 1) - 6'(cnt_q);
`ifdef INT_TO_FP8_ROUND_EN
    guard    = mag_q[IN_W-5];
    sticky   = |(mag_q & STICKY_MASK);
    round_up = guard && (sticky || mant_t[0]);
    mant_sum = {1'b0, mant_t} + {3'b000, round_up};
    mant_r   = mant_sum[2:0];
    expo_r   = expo_t + {5'b00000, mant_sum[3]};
`else
    mant_r   = mant_t;
    expo_r   = expo_t;
`endif
    if (mag_q == '0) begin
      packed_res = 8'h00;
    end else if (expo_r >= 6'd15) begin
      packed_res = {sign_q, 4'hF, 3'b000};
    end else begin
      packed_res = {sign_q, expo_r[3:0], mant_r};
    end
  end

  // Next-state logic for the conversion FSM and its datapath.
  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    mag_d       = mag_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_data[IN_W-1];
          mag_d   = abs_in;
          cnt_d   = '0;
          state_d = NORM;
        end
      end
      NORM: begin
        if ((mag_q == '0) || mag_q[IN_W-1]) begin
          state_d = PACK;
        end else begin
          mag_d = mag_q << 1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PACK: begin
        out_data_d  = packed_res;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; synchronous reset drops any in-flight conversion.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      mag_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      mag_q       <= mag_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_int_to_fp8_encoder.sv
// Directed bench for int_to_fp8_encoder with IN_W=8, BIAS=7.
// Checks reset state, encodings, latency, backpressure hold and mid-conversion reset.
// Expected values are hand-computed; rounding-dependent values follow INT_TO_FP8_ROUND_EN.
module tb_int_to_fp8_encoder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;

  int errors = 0;
  int checks = 0;

  int_to_fp8_encoder #(.IN_W(8), .BIAS(7)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after the accept edge; waits for out_valid and checks latency and data.
  task automatic wait_result(input string tag, input int exp_data, input int exp_lat);
    int lat;
    lat = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_data"}, int'(out_data), exp_data);
    check({tag, "_busy"}, int'(busy), 1);
  endtask

  task automatic accept(input string tag, input logic [7:0] val);
    @(negedge clk);
    in_data  = val;
    in_valid = 1'b1;
    check({tag, "_in_ready"}, int'(in_ready), 1);
    @(posedge clk);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_vld_low"}, int'(out_valid), 0);
    check({tag, "_idle"}, int'(busy), 0);
  endtask

  task automatic convert(input string tag, input logic [7:0] val, input int exp_data, input int exp_lat);
    accept(tag, val);
    wait_result(tag, exp_data, exp_lat);
    handshake(tag);
  endtask

  initial begin
    int exp124;
    int exp127;
    int seen;
`ifdef INT_TO_FP8_ROUND_EN
    exp124 = 'h70;
    exp127 = 'h70;
`else
    exp124 = 'h6F;
    exp127 = 'h6F;
`endif
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_busy", int'(busy), 0);

    convert("zero", 8'd0, 'h00, 2);
    convert("neg1", 8'hFF, 'hB8, 9);
    convert("neg128", 8'h80, 'hF0, 2);
    convert("pos1", 8'd1, 'h38, 9);
    convert("pos100", 8'd100, 'h6C, 3);
    convert("pos124", 8'd124, exp124, 3);
    convert("pos127", 8'd127, exp127, 3);
    convert("pos5", 8'd5, 'h4A, 7);
    convert("neg3", 8'hFD, 'hC4, 8);

    // Backpressure: hold result while a second input is presented and ignored.
    accept("bp", 8'd100);
    wait_result("bp", 'h6C, 3);
    in_valid = 1'b1;
    in_data  = 8'd5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_data", int'(out_data), 'h6C);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_hold_vld", int'(out_valid), 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_vld", int'(out_valid), 0);
    check("bp_release_rdy", int'(in_ready), 1);
    @(posedge clk);
    wait_result("bp2", 'h4A, 7);
    handshake("bp2");

    // Reset in the middle of normalising input 1.
    accept("rst_mid", 8'd1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    check("rstmid_out_valid", int'(out_valid), 0);
    check("rstmid_out_data", int'(out_data), 0);
    check("rstmid_in_ready", int'(in_ready), 1);
    check("rstmid_busy", int'(busy), 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rstmid_no_stale", seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
